div_ctrl: RTL and testbench
===========================

# div_ctrl

EX-stage issue controller for the multi-cycle divider: the initiator side of the divider's start/cancel/ready handshake. It sits beside the divider in the EX stage of the MIPS core. On DIV/DIVU it registers the operands and holds `div_start` until the divider reports ready. Meanwhile it requests a pipeline stall, converts flushes into `div_cancel`, commits `{remainder, quotient}` to HI/LO, and enforces divider recovery cycles between operations.

## Interface
- No parameters. Widths come from the shared macros `REG_DATA_WIDTH` (32) and `DOUBLE_DATA_WIDTH` (64).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ex_div_op_in`  in  1  EX holds a DIV/DIVU.
- `ex_signed_in`  in  1  1 = DIV, 0 = DIVU.
- `ex_rs_data_in`  in  32  dividend.
- `ex_rt_data_in`  in  32  divisor.
- `flush_in`  in  1  pipeline flush.
- `div_res_in`  in  64  divider result: [63:32] remainder, [31:0] quotient.
- `div_ready_in`  in  1  divider result valid; held while start stays high.
- `div_start_out`  out  1  divider start, registered.
- `div_cancel_out`  out  1  divider cancel, combinational.
- `div_signed_out`  out  1  registered signedness.
- `div_op1_out`  out  32  registered dividend.
- `div_op2_out`  out  32  registered divisor.
- `stall_req_out`  out  1  stall request to pipeline control, combinational.
- `hilo_we_out`  out  1  HI/LO write strobe, one-cycle pulse.
- `hi_out`  out  32  remainder.
- `lo_out`  out  32  quotient.

## Operation
- States: IDLE, BUSY, DRAIN1, DRAIN2.
- **IDLE**
  - If `ex_div_op_in & !flush_in`: capture rs, rt and signed into the op registers, set `div_start_out` to 1, go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**
  - `div_start_out` and the operand registers are held unchanged. The divider requires operands stable for the whole operation.
  - If `flush_in`: clear `div_start_out`, go to DRAIN1. No HI/LO write.
  - Else if `div_ready_in`: latch `hi_out` ← `div_res_in[63:32]` and `lo_out` ← `div_res_in[31:0]`, set `hilo_we_out` to 1, clear `div_start_out`, go to DRAIN1.
  - Flush has priority over ready in the same cycle: the result is dropped.
- **DRAIN1**: `hilo_we_out` returns to 0. Go to DRAIN2. Flush is ignored; a commit already made stands.
- **DRAIN2**: go to IDLE.
- The two drain cycles with start low let the divider return to its free state from any internal state, including its divide-by-zero path. A new DIV is never launched before IDLE.
- `div_cancel_out` = (BUSY & `flush_in`) | DRAIN1 | DRAIN2.
- `stall_req_out`:
  - IDLE: `ex_div_op_in & !flush_in`.
  - BUSY: `!flush_in`. This includes the ready cycle.
  - DRAIN1: 0. The committed DIV leaves EX at the end of this cycle.
  - DRAIN2: `ex_div_op_in`, which holds a following DIV.
  - Forced to 0 while `rst_n` is low.
- Divide-by-zero: no special handling here. The divider returns 0, so HI = LO = 0 is committed.
- `hi_out`/`lo_out` hold their value until the next commit.

## Timing
- Reset: state IDLE; `div_start_out`, `div_signed_out`, `div_op1_out`, `div_op2_out`, `hilo_we_out`, `hi_out`, `lo_out` all 0.
- Reset asserted mid-operation clears everything immediately, without a clock edge.
- The divider sees start the cycle after the IDLE accept.
- Latency is set by `div_ready_in`. The commit is visible on `hi_out`/`lo_out`/`hilo_we_out` in the cycle after the first ready cycle (DRAIN1).
- Minimum spacing from a ready cycle to the next `div_start_out` rise is 4 cycles: DRAIN1, DRAIN2, IDLE accept, then start high.
- `div_ready_in` seen outside BUSY is ignored.

## Structure
- State encodings go in the shared defines header next to the existing `DIV_*` divider states: `DIVC_IDLE`, `DIVC_BUSY`, `DIVC_DRAIN1`, `DIVC_DRAIN2`, 2 bits.
- No sub-module. The block is instantiated in EX alongside the divider, with ports wired one-to-one to the divider's start/cancel/signed/operand/result/ready pins.

## Test plan
- **Unsigned 100/7**: DIVU with rs=100, rt=7 → one `hilo_we_out` pulse with HI=2, LO=14. `stall_req_out` is high from the accept cycle through the ready cycle, then low in DRAIN1.
- **Signed -100/7**: DIV with rs=0xFFFFFF9C, rt=7 → LO=0xFFFFFFF2 (-14), HI=0xFFFFFFFE (-2).
- **Divide by zero**: DIV with rs=5, rt=0 → HI=LO=0, a single write pulse, clean return to IDLE.
- **Flush mid-operation**: flush 10 cycles after start →
  - `div_cancel_out` high that cycle and through both drain cycles;
  - start low the next cycle;
  - no `hilo_we_out`;
  - a subsequent 50/5 yields LO=10, HI=0.
- **Back-to-back DIVs**: 9/2 then 40/6 → results HI=1, LO=4 then HI=4, LO=6. The second start rises exactly 4 cycles after the first ready cycle.
- **Reset mid-BUSY**: `rst_n` low → all outputs 0 asynchronously, state IDLE; a post-reset DIV completes correctly.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl_pkg
// Description : Shared widths and controller state encoding for div_ctrl.
//               The DIVC_* states sit beside the divider's own DIV_* states.
// Revision    : 1.0 - initial release
// ============================================================================
package div_ctrl_pkg;

    localparam int REG_DATA_WIDTH    = 32;
    localparam int DOUBLE_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        DIVC_IDLE   = 2'd0,
        DIVC_BUSY   = 2'd1,
        DIVC_DRAIN1 = 2'd2,
        DIVC_DRAIN2 = 2'd3
    } divc_state_e;

endpackage : div_ctrl_pkg
`default_nettype wire

// File: rtl/div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_ctrl
// Description : EX-stage issue controller for the multi-cycle divider.
//               Registers DIV/DIVU operands, holds div_start_out until the
//               divider reports ready, stalls the pipeline meanwhile, turns
//               flushes into div_cancel_out, commits {remainder, quotient}
//               to HI/LO and inserts two recovery cycles after every op.
// Ports       :
//   clk, rst_n                      clock / async active-low reset
//   ex_div_op_in, ex_signed_in      DIV/DIVU present in EX, 1 = signed
//   ex_rs_data_in, ex_rt_data_in    dividend / divisor
//   flush_in                        pipeline flush
//   div_res_in, div_ready_in        divider result {rem, quo} and valid
//   div_start_out, div_cancel_out   divider start (reg) / cancel (comb)
//   div_signed_out, div_op1_out,
//   div_op2_out                     registered operands to the divider
//   stall_req_out                   stall request (comb)
//   hilo_we_out, hi_out, lo_out     HI/LO commit pulse and data
// Revision    : 1.0 - initial release
// ============================================================================
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ex_div_op_in,
    input  logic                         ex_signed_in,
    input  logic [REG_DATA_WIDTH-1:0]    ex_rs_data_in,
    input  logic [REG_DATA_WIDTH-1:0]    ex_rt_data_in,
    input  logic                         flush_in,
    input  logic [DOUBLE_DATA_WIDTH-1:0] div_res_in,
    input  logic                         div_ready_in,
    output logic                         div_start_out,
    output logic                         div_cancel_out,
    output logic                         div_signed_out,
    output logic [REG_DATA_WIDTH-1:0]    div_op1_out,
    output logic [REG_DATA_WIDTH-1:0]    div_op2_out,
    output logic                         stall_req_out,
    output logic                         hilo_we_out,
    output logic [REG_DATA_WIDTH-1:0]    hi_out,
    output logic [REG_DATA_WIDTH-1:0]    lo_out
);

    divc_state_e r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= DIVC_IDLE;
            div_start_out  <= 1'b0;
            div_signed_out <= 1'b0;
            div_op1_out    <= '0;
            div_op2_out    <= '0;
            hilo_we_out    <= 1'b0;
            hi_out         <= '0;
            lo_out         <= '0;
        end else begin
            // Commit strobe is a single-cycle pulse.
            hilo_we_out <= 1'b0;
            case (r_state)
                DIVC_IDLE: begin
                    if (ex_div_op_in && !flush_in) begin
                        div_signed_out <= ex_signed_in;
                        div_op1_out    <= ex_rs_data_in;
                        div_op2_out    <= ex_rt_data_in;
                        div_start_out  <= 1'b1;
                        r_state        <= DIVC_BUSY;
                    end
                end
                DIVC_BUSY: begin
                    // Operands and start stay frozen; flush wins over ready
                    // so a squashed DIV never writes HI/LO.
                    if (flush_in) begin
                        div_start_out <= 1'b0;
                        r_state       <= DIVC_DRAIN1;
                    end else if (div_ready_in) begin
                        hi_out        <= div_res_in[DOUBLE_DATA_WIDTH-1:REG_DATA_WIDTH];
                        lo_out        <= div_res_in[REG_DATA_WIDTH-1:0];
                        hilo_we_out   <= 1'b1;
                        div_start_out <= 1'b0;
                        r_state       <= DIVC_DRAIN1;
                    end
                end
                // Two cycles with start low let the divider fall back to its
                // free state from anywhere, including the divide-by-zero path.
                DIVC_DRAIN1: r_state <= DIVC_DRAIN2;
                DIVC_DRAIN2: r_state <= DIVC_IDLE;
                default:     r_state <= DIVC_IDLE;
            endcase
        end
    end

    assign div_cancel_out = ((r_state == DIVC_BUSY) && flush_in)
                          || (r_state == DIVC_DRAIN1)
                          || (r_state == DIVC_DRAIN2);

    always_comb begin
        stall_req_out = 1'b0;
        case (r_state)
            DIVC_IDLE:   stall_req_out = ex_div_op_in && !flush_in;
            DIVC_BUSY:   stall_req_out = !flush_in;
            // The committed DIV leaves EX at the end of DRAIN1.
            DIVC_DRAIN1: stall_req_out = 1'b0;
            // A following DIV is held until the controller is back in IDLE.
            DIVC_DRAIN2: stall_req_out = ex_div_op_in;
            default:     stall_req_out = 1'b0;
        endcase
        if (!rst_n) begin
            stall_req_out = 1'b0;
        end
    end

endmodule : div_ctrl
`default_nettype wire

// File: tb/tb_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_ctrl
// Description : Self-checking bench for div_ctrl. Emulates the divider and
//               keeps a behavioural model of the controller (busy flag plus
//               a recovery countdown) with arithmetic reference division.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_div_op_in = 1'b0;
    logic        ex_signed_in = 1'b0;
    logic [31:0] ex_rs_data_in = '0;
    logic [31:0] ex_rt_data_in = '0;
    logic        flush_in = 1'b0;
    logic [63:0] div_res_in = '0;
    logic        div_ready_in = 1'b0;
    logic        div_start_out, div_cancel_out, div_signed_out;
    logic [31:0] div_op1_out, div_op2_out;
    logic        stall_req_out, hilo_we_out;
    logic [31:0] hi_out, lo_out;

    div_ctrl u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_div_op_in   (ex_div_op_in),
        .ex_signed_in   (ex_signed_in),
        .ex_rs_data_in  (ex_rs_data_in),
        .ex_rt_data_in  (ex_rt_data_in),
        .flush_in       (flush_in),
        .div_res_in     (div_res_in),
        .div_ready_in   (div_ready_in),
        .div_start_out  (div_start_out),
        .div_cancel_out (div_cancel_out),
        .div_signed_out (div_signed_out),
        .div_op1_out    (div_op1_out),
        .div_op2_out    (div_op2_out),
        .stall_req_out  (stall_req_out),
        .hilo_we_out    (hilo_we_out),
        .hi_out         (hi_out),
        .lo_out         (lo_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: busy flag, remaining recovery cycles, HI/LO, operands.
    bit          m_busy;
    int          m_drain;
    bit          m_we;
    bit          m_sgn;
    logic [31:0] m_op1, m_op2, m_hi, m_lo;

    // Divider emulation and bookkeeping.
    int  emu_lat   = 0;
    int  emu_cnt   = 0;
    bit  spurious  = 0;
    bit  prev_start = 0;
    int  cycn      = 0;
    int  last_rise = 0;
    int  last_ready = 0;
    int  n_we_seen = 0;
    bit  s_cancel, s_stall, s_start;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cycn);
    endtask

    // MIPS DIV/DIVU: truncating quotient, remainder takes dividend sign,
    // divide-by-zero yields zero. Result packed as {remainder, quotient}.
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint na, nb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_drain = 0; m_we = 0; m_sgn = 0;
        m_op1 = '0; m_op2 = '0; m_hi = '0; m_lo = '0;
        emu_cnt = 0; prev_start = 0;
    endtask

    // One clock cycle: drive inputs, emulate divider, compare at negedge,
    // advance model, return 1 time unit after the next rising edge.
    task automatic cyc(input bit op, input bit sgn, input logic [31:0] rs,
                       input logic [31:0] rt, input bit fl);
        logic [63:0] r;
        bit e_stall, e_cancel;
        ex_div_op_in = op; ex_signed_in = sgn;
        ex_rs_data_in = rs; ex_rt_data_in = rt; flush_in = fl;
        if (div_start_out) begin
            if (!prev_start) last_rise = cycn;
            div_ready_in = (emu_cnt >= emu_lat);
            div_res_in   = ref_div(div_signed_out, div_op1_out, div_op2_out);
            emu_cnt++;
        end else begin
            emu_cnt      = 0;
            div_ready_in = spurious && ($urandom_range(0, 7) == 0);
            div_res_in   = {$urandom, $urandom};
        end
        e_cancel = (m_busy && fl) || (m_drain > 0);
        if (m_busy)            e_stall = !fl;
        else if (m_drain == 2) e_stall = 1'b0;
        else if (m_drain == 1) e_stall = op;
        else                   e_stall = op && !fl;

        @(negedge clk);
        s_cancel = div_cancel_out; s_stall = stall_req_out; s_start = div_start_out;
        if (hilo_we_out) n_we_seen++;
        chk("start",  div_start_out,  m_busy);
        chk("cancel", div_cancel_out, e_cancel);
        chk("stall",  stall_req_out,  e_stall);
        chk("hilo_we", hilo_we_out,   m_we);
        chk("hi",     hi_out,         m_hi);
        chk("lo",     lo_out,         m_lo);
        chk("op1",    div_op1_out,    m_op1);
        chk("op2",    div_op2_out,    m_op2);
        chk("signed", div_signed_out, m_sgn);

        m_we = 0;
        if (m_busy) begin
            if (fl) begin
                m_busy = 0; m_drain = 2;
            end else if (div_ready_in) begin
                r = ref_div(m_sgn, m_op1, m_op2);
                m_hi = r[63:32]; m_lo = r[31:0];
                m_we = 1; m_busy = 0; m_drain = 2;
                last_ready = cycn;
            end
        end else if (m_drain > 0) begin
            m_drain--;
        end else if (op && !fl) begin
            m_busy = 1; m_sgn = sgn; m_op1 = rs; m_op2 = rt;
        end
        prev_start = div_start_out;
        @(posedge clk); #1;
        cycn++;
    endtask

    // Present a DIV until accepted, wait for commit, check against literals.
    // Returns at the DRAIN1 cycle with the commit visible.
    task automatic do_div(input string name, input bit sgn, input logic [31:0] rs,
                          input logic [31:0] rt, input int lat,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int k;
        emu_lat = lat;
        k = 0;
        while (!m_busy && k < 100) begin cyc(1, sgn, rs, rt, 0); k++; end
        k = 0;
        while (!m_we && k < 200) begin cyc(0, sgn, rs, rt, 0); k++; end
        if (!m_we) chk({name, "_timeout"}, 0, 1);
        chk({name, "_hi"}, hi_out, exp_hi);
        chk({name, "_lo"}, lo_out, exp_lo);
        chk({name, "_we"}, hilo_we_out, 1);
    endtask

    initial begin
        int w0, r1;
        bit rop, rfl;
        logic [31:0] rrs, rrt;
        model_reset();

        // Reset state, with a DIV presented while reset is held.
        ex_div_op_in = 1'b1;
        @(posedge clk); #1;
        chk("rst_stall", stall_req_out, 0);
        chk("rst_start", div_start_out, 0);
        chk("rst_hilo", {hi_out, lo_out}, 64'd0);
        chk("rst_ops", {div_op1_out, div_op2_out}, 64'd0);
        ex_div_op_in = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0);

        // Unsigned 100/7, stall drops in DRAIN1.
        do_div("divu_100_7", 0, 32'd100, 32'd7, 5, 32'd2, 32'd14);
        cyc(0, 0, 0, 0, 0);
        chk("divu_drain1_stall", s_stall, 0);
        cyc(0, 0, 0, 0, 0);

        // Signed -100/7.
        do_div("div_m100_7", 1, 32'hFFFFFF9C, 32'd7, 3, 32'hFFFFFFFE, 32'hFFFFFFF2);
        cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);

        // Divide by zero: zeros committed, exactly one write pulse.
        w0 = n_we_seen;
        do_div("div_5_0", 1, 32'd5, 32'd0, 2, 32'd0, 32'd0);
        cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        chk("divzero_pulses", n_we_seen - w0, 1);

        // Flush 10 cycles after start.
        emu_lat = 30;
        while (!m_busy) cyc(1, 0, 32'd77, 32'd3, 0);
        w0 = n_we_seen;
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("flush_cancel", s_cancel, 1);
        cyc(0, 0, 0, 0, 0);
        chk("flush_start_low", s_start, 0);
        chk("flush_drain1_cancel", s_cancel, 1);
        cyc(0, 0, 0, 0, 0);
        chk("flush_drain2_cancel", s_cancel, 1);
        cyc(0, 0, 0, 0, 0);
        chk("flush_no_we", n_we_seen - w0, 0);
        do_div("div_50_5", 0, 32'd50, 32'd5, 4, 32'd0, 32'd10);
        cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);

        // Back-to-back: second start rises 4 cycles after first ready.
        do_div("b2b_9_2", 0, 32'd9, 32'd2, 3, 32'd1, 32'd4);
        r1 = last_ready;
        cyc(0, 0, 0, 0, 0);
        do_div("b2b_40_6", 0, 32'd40, 32'd6, 2, 32'd4, 32'd6);
        chk("b2b_gap", last_rise - r1, 4);
        cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);

        // Reset in the middle of BUSY clears everything without a clock edge.
        emu_lat = 40;
        while (!m_busy) cyc(1, 1, 32'd123, 32'd9, 0);
        cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        ex_div_op_in = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("arst_start", div_start_out, 0);
        chk("arst_stall", stall_req_out, 0);
        chk("arst_cancel", div_cancel_out, 0);
        chk("arst_we", hilo_we_out, 0);
        chk("arst_hilo", {hi_out, lo_out}, 64'd0);
        chk("arst_ops", {div_signed_out, div_op1_out, div_op2_out}, 65'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ex_div_op_in = 1'b0;
        model_reset();
        cyc(0, 0, 0, 0, 0);
        do_div("post_rst_1000_33", 0, 32'd1000, 32'd33, 6, 32'd10, 32'd30);
        cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);

        // Randomized traffic with spurious ready outside BUSY.
        spurious = 1;
        for (int i = 0; i < 800; i++) begin
            if (!div_start_out) emu_lat = $urandom_range(0, 8);
            rop = ($urandom_range(0, 2) == 0);
            rfl = ($urandom_range(0, 15) == 0);
            rrs = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 200);
            case ($urandom_range(0, 3))
                0:       rrt = 32'd0;
                1:       rrt = $urandom;
                2:       rrt = 32'hFFFFFFFF;
                default: rrt = $urandom_range(1, 20);
            endcase
            cyc(rop, 1'($urandom_range(0, 1)), rrs, rrt, rfl);
        end
        spurious = 0;
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_div_ctrl
`default_nettype wire
